// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, opcodes,
// funct3 codes and access-size decoding helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Any funct3 without a defined meaning for the op type falls back to word.
  function automatic lsu_size_e access_size(input logic is_store, input logic [2:0] f3);
    lsu_size_e sz;
    sz = SZ_WORD;
    case (f3)
      F3_B:    sz = SZ_BYTE;
      F3_H:    sz = SZ_HALF;
      F3_BU:   sz = is_store ? SZ_WORD : SZ_BYTE;
      F3_HU:   sz = is_store ? SZ_WORD : SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (sz)
      SZ_HALF: mis = lo[0];
      SZ_WORD: mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_fmt.sv
// Combinational data formatter: store byte-lane alignment and byte enables,
// plus load lane extraction with sign/zero extension.
module lsu_fmt
  import lsu_pkg::*;
(
  input  lsu_size_e   size_i,
  input  logic        sign_ext_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = rdata_i[7:0];
    case (offset_i)
      2'd0:    rbyte = rdata_i[7:0];
      2'd1:    rbyte = rdata_i[15:8];
      2'd2:    rbyte = rdata_i[23:16];
      default: rbyte = rdata_i[31:24];
    endcase
    rhalf = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    load_o  = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
        load_o  = {{24{sign_ext_i & rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        load_o  = {{16{sign_ext_i & rhalf[15]}}, rhalf};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        load_o  = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: IDLE/REQ/WAIT/DONE sequencing of one data-bus access.
// Build option LSU_MISALIGN_TRAP_EN: misaligned ops are trapped instead of issued.
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [6:0]  instr_opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        stall,
  output logic        misalign,
  output lsu_state_e  dbg_state_o
);

  // Bus handshake: dbus_req and its attributes (we/addr/be/wdata) are held
  // constant from the first REQ cycle until the cycle dbus_gnt is seen high;
  // the access is transferred in that cycle. For loads, read data is taken on
  // the first dbus_rvalid in WAIT; gnt/rvalid in any other state are ignored.

  lsu_state_e  state_q, state_d;
  logic        dbus_req_q, dbus_we_q, load_valid_q;
  logic [31:0] dbus_addr_q, dbus_wdata_q, load_data_q;
  logic [3:0]  dbus_be_q;
  lsu_size_e   size_q;
  logic        sign_q;
  logic [1:0]  offset_q;

  logic        is_load, is_store, mem_op, in_mis, trap, accept, fsm_stall;
  lsu_size_e   in_size;
  logic [1:0]  in_offset;

  lsu_size_e   fmt_size;
  logic        fmt_sign;
  logic [1:0]  fmt_offset;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata, fmt_load;

  assign is_load  = ex_valid && (instr_opcode == OPC_LOAD);
  assign is_store = ex_valid && (instr_opcode == OPC_STORE);
  assign mem_op   = is_load || is_store;
  assign in_size  = access_size(is_store, funct3);
  assign in_mis   = is_misaligned(in_size, addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap     = mem_op && in_mis;
  assign misalign = !rst && (state_q == IDLE) && trap;
`else
  assign trap     = 1'b0;
  assign misalign = 1'b0;
`endif

  assign accept = (state_q == IDLE) && mem_op && !trap;

  // Offending low address bits are dropped so a misaligned op still lands on a legal lane.
  always_comb begin
    in_offset = 2'b00;
    case (in_size)
      SZ_BYTE: in_offset = addr[1:0];
      SZ_HALF: in_offset = {addr[1], 1'b0};
      default: in_offset = 2'b00;
    endcase
  end

  // Formatter serves store alignment at accept time and load extraction in WAIT.
  always_comb begin
    fmt_size   = size_q;
    fmt_sign   = sign_q;
    fmt_offset = offset_q;
    if (state_q == IDLE) begin
      fmt_size   = in_size;
      fmt_sign   = !funct3[2];
      fmt_offset = in_offset;
    end
  end

  lsu_fmt u_fmt (
    .size_i     (fmt_size),
    .sign_ext_i (fmt_sign),
    .offset_i   (fmt_offset),
    .wdata_i    (wdata),
    .rdata_i    (dbus_rdata),
    .be_o       (fmt_be),
    .wdata_o    (fmt_wdata),
    .load_o     (fmt_load)
  );

  always_comb begin
    state_d   = state_q;
    fsm_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = REQ;
          fsm_stall = 1'b1;
        end
      end
      REQ: begin
        fsm_stall = 1'b1;
        if (dbus_gnt) state_d = dbus_we_q ? DONE : WAIT;
      end
      WAIT: begin
        fsm_stall = 1'b1;
        if (dbus_rvalid) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall = rst ? mem_op : fsm_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dbus_req_q   <= 1'b0;
      dbus_we_q    <= 1'b0;
      dbus_addr_q  <= 32'd0;
      dbus_be_q    <= 4'd0;
      dbus_wdata_q <= 32'd0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      size_q       <= SZ_WORD;
      sign_q       <= 1'b0;
      offset_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      load_valid_q <= 1'b0;
      if (accept) begin
        dbus_req_q   <= 1'b1;
        dbus_we_q    <= is_store;
        dbus_addr_q  <= {addr[31:2], 2'b00};
        dbus_be_q    <= fmt_be;
        dbus_wdata_q <= is_store ? fmt_wdata : 32'd0;
        size_q       <= in_size;
        sign_q       <= !funct3[2];
        offset_q     <= in_offset;
      end
      if ((state_q == REQ) && dbus_gnt) dbus_req_q <= 1'b0;
      if ((state_q == WAIT) && dbus_rvalid) begin
        load_data_q  <= fmt_load;
        load_valid_q <= 1'b1;
      end
    end
  end

  assign dbus_req    = dbus_req_q;
  assign dbus_we     = dbus_we_q;
  assign dbus_addr   = dbus_addr_q;
  assign dbus_be     = dbus_be_q;
  assign dbus_wdata  = dbus_wdata_q;
  assign load_data   = load_data_q;
  assign load_valid  = load_valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl; a small bus responder grants and
// returns read data after programmable delays.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [6:0]  instr_opcode;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic [31:0] load_data;
  logic        load_valid, stall, misalign;
  lsu_state_e  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-transaction observations gathered by do_op.
  int          r_stall, r_lv, r_req, r_mis;
  logic        r_stable, r_we;
  logic [31:0] r_addr, r_wdata, r_ld;
  logic [3:0]  r_be;
  lsu_state_e  r_first_state;

  lsu_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .instr_opcode (instr_opcode),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .dbus_req     (dbus_req),
    .dbus_we      (dbus_we),
    .dbus_addr    (dbus_addr),
    .dbus_be      (dbus_be),
    .dbus_wdata   (dbus_wdata),
    .dbus_gnt     (dbus_gnt),
    .dbus_rvalid  (dbus_rvalid),
    .dbus_rdata   (dbus_rdata),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .stall        (stall),
    .misalign     (misalign),
    .dbg_state_o  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; presents the op and runs until stall drops.
  task automatic do_op(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int gnt_dly, input int rv_dly);
    int   req_seen, wait_seen;
    logic waiting, done;
    r_stall = 0; r_lv = 0; r_req = 0; r_mis = 0; r_stable = 1'b1; r_we = 1'b0;
    r_addr = '0; r_wdata = '0; r_ld = '0; r_be = '0; r_first_state = IDLE;
    req_seen = 0; wait_seen = 0; waiting = 1'b0; done = 1'b0;
    ex_valid = 1'b1; instr_opcode = opc; funct3 = f3; addr = a; wdata = wd; dbus_rdata = rd;
    for (int c = 0; c < 40 && !done; c++) begin
      dbus_gnt    = dbus_req && (req_seen == gnt_dly);
      dbus_rvalid = waiting && (wait_seen == rv_dly);
      #1;
      if (c == 0) r_first_state = dbg_state;
      if (stall) r_stall++;
      if (misalign) r_mis++;
      if (load_valid) begin
        r_lv++;
        r_ld = load_data;
      end
      if (dbus_req) begin
        if (req_seen == 0) begin
          r_we = dbus_we; r_addr = dbus_addr; r_be = dbus_be; r_wdata = dbus_wdata;
        end else if ({dbus_we, dbus_addr, dbus_be, dbus_wdata} !== {r_we, r_addr, r_be, r_wdata}) begin
          r_stable = 1'b0;
        end
        req_seen++;
      end
      r_req = req_seen;
      if (waiting) begin
        if (dbus_rvalid) waiting = 1'b0;
        else wait_seen++;
      end else if (dbus_gnt && !dbus_we) begin
        waiting = 1'b1;
      end
      if (!stall) done = 1'b1;
      @(negedge clk);
    end
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    check("op_done", {31'd0, done}, 32'd1);
  endtask

  task automatic go_idle();
    ex_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; instr_opcode = '0; funct3 = '0; addr = '0; wdata = '0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", dbg_state, IDLE);
    check("rst_req", dbus_req, 0);
    check("rst_we", dbus_we, 0);
    check("rst_addr", dbus_addr, 0);
    check("rst_be", dbus_be, 0);
    check("rst_wdata", dbus_wdata, 0);
    check("rst_load_data", load_data, 0);
    check("rst_load_valid", load_valid, 0);
    check("rst_misalign", misalign, 0);
    check("rst_stall_noop", stall, 0);
    ex_valid = 1'b1; instr_opcode = OPC_LOAD; funct3 = F3_W; addr = 32'h10;
    #1;
    check("rst_stall_memop", stall, 1);
    @(negedge clk);
    rst = 1'b0; ex_valid = 1'b0;
    @(negedge clk);

    // SW 0x100, granted on first REQ cycle
    do_op(OPC_STORE, F3_W, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
    check("sw_stall", r_stall, 2);
    check("sw_addr", r_addr, 32'h100);
    check("sw_be", r_be, 4'b1111);
    check("sw_wdata", r_wdata, 32'hDEADBEEF);
    check("sw_we", r_we, 1);
    check("sw_req_cycles", r_req, 1);
    check("sw_no_lv", r_lv, 0);
    go_idle();

    // LB 0x203, read data after two empty WAIT cycles
    do_op(OPC_LOAD, F3_B, 32'h203, 32'h0, 32'h80123456, 0, 2);
    check("lb_stall", r_stall, 5);
    check("lb_addr", r_addr, 32'h200);
    check("lb_be", r_be, 4'b1000);
    check("lb_we", r_we, 0);
    check("lb_lv_pulses", r_lv, 1);
    check("lb_data", r_ld, 32'hFFFFFF80);
    ex_valid = 1'b0;
    #1;
    check("lb_lv_after", load_valid, 0);
    check("lb_state_after", dbg_state, IDLE);
    @(negedge clk);

    // SH 0x302, grant delayed 3 cycles: request must hold steady
    do_op(OPC_STORE, F3_H, 32'h302, 32'h0000ABCD, 32'h0, 3, 0);
    check("sh_be", r_be, 4'b1100);
    check("sh_wdata", r_wdata, 32'hABCDABCD);
    check("sh_stable", r_stable, 1);
    check("sh_req_cycles", r_req, 4);
    check("sh_stall", r_stall, 5);
    check("sh_addr", r_addr, 32'h300);
    go_idle();

    // LW 0x401 misaligned
    do_op(OPC_LOAD, F3_W, 32'h401, 32'h0, 32'h11223344, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_pulse", r_mis, 1);
    check("lw_mis_req", r_req, 0);
    check("lw_mis_stall", r_stall, 0);
    ex_valid = 1'b0;
    #1;
    check("lw_mis_after", misalign, 0);
    check("lw_mis_req_after", dbus_req, 0);
    @(negedge clk);
`else
    check("lw_mis_addr", r_addr, 32'h400);
    check("lw_mis_be", r_be, 4'b1111);
    check("lw_mis_data", r_ld, 32'h11223344);
    check("lw_mis_flag", r_mis, 0);
    check("lw_mis_stall", r_stall, 3);
    go_idle();
`endif

    // Lane/extension vectors
    do_op(OPC_LOAD, F3_HU, 32'h206, 32'h0, 32'h9ABC1234, 1, 0);
    check("lhu_be", r_be, 4'b1100);
    check("lhu_data", r_ld, 32'h00009ABC);
    check("lhu_stall", r_stall, 4);
    go_idle();
    do_op(OPC_LOAD, F3_H, 32'h206, 32'h0, 32'h9ABC1234, 0, 1);
    check("lh_data", r_ld, 32'hFFFF9ABC);
    go_idle();
    do_op(OPC_LOAD, F3_BU, 32'h201, 32'h0, 32'h0000F700, 0, 0);
    check("lbu_be", r_be, 4'b0010);
    check("lbu_data", r_ld, 32'h000000F7);
    go_idle();
    do_op(OPC_STORE, F3_B, 32'h103, 32'h000000A5, 32'h0, 0, 0);
    check("sb_be", r_be, 4'b1000);
    check("sb_wdata", r_wdata, 32'hA5A5A5A5);
    go_idle();
    do_op(OPC_LOAD, 3'b011, 32'h500, 32'h0, 32'h87654321, 0, 0);
    check("f3x_be", r_be, 4'b1111);
    check("f3x_data", r_ld, 32'h87654321);
    go_idle();
    do_op(7'b0110011, F3_W, 32'h500, 32'h0, 32'h0, 0, 0);
    check("nonmem_stall", r_stall, 0);
    check("nonmem_req", r_req, 0);
    go_idle();

    // Reset while in WAIT, then a stray rvalid
    ex_valid = 1'b1; instr_opcode = OPC_LOAD; funct3 = F3_W; addr = 32'h600; dbus_rdata = 32'h55AA55AA;
    @(negedge clk);
    dbus_gnt = dbus_req;
    @(negedge clk);
    dbus_gnt = 1'b0;
    #1;
    check("rstw_in_wait", dbg_state, WAIT);
    rst = 1'b1; ex_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; dbus_rvalid = 1'b1;
    #1;
    check("rstw_state", dbg_state, IDLE);
    check("rstw_stall", stall, 0);
    check("rstw_lv", load_valid, 0);
    @(negedge clk);
    dbus_rvalid = 1'b0;
    #1;
    check("rstw_lv_after", load_valid, 0);
    check("rstw_state_after", dbg_state, IDLE);
    check("rstw_req", dbus_req, 0);
    @(negedge clk);

    // Back-to-back LW then SW: SW accepted in the IDLE cycle after LW's DONE
    do_op(OPC_LOAD, F3_W, 32'h700, 32'h0, 32'hCAFEF00D, 0, 0);
    check("b2b_lw_data", r_ld, 32'hCAFEF00D);
    check("b2b_lw_req_cycles", r_req, 1);
    do_op(OPC_STORE, F3_W, 32'h704, 32'h12345678, 32'h0, 0, 0);
    check("b2b_sw_first_state", r_first_state, IDLE);
    check("b2b_sw_addr", r_addr, 32'h704);
    check("b2b_sw_wdata", r_wdata, 32'h12345678);
    check("b2b_sw_we", r_we, 1);
    check("b2b_sw_stall", r_stall, 2);
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 ex_valid  in  1  execute-stage instruction valid.
REQ-004 instr_opcode  in  7  opcode of execute-stage instruction.
REQ-005 funct3  in  3  width/sign code (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010).
REQ-006 addr  in  32  effective address (ALU result).
REQ-007 wdata  in  32  store data (rs2).
REQ-008 dbus_req  out  1  bus request, registered.
REQ-009 dbus_we  out  1  1=store, 0=load.
REQ-010 dbus_addr  out  32  word address; bits [1:0] = 0.
REQ-011 dbus_be  out  4  byte enables.
REQ-012 dbus_wdata  out  32  lane-aligned store data.
REQ-013 dbus_gnt  in  1  bus accepts request this cycle.
REQ-014 dbus_rvalid  in  1  read data valid.
REQ-015 dbus_rdata  in  32  read data.
REQ-016 load_data  out  32  extended load result, registered.
REQ-017 load_valid  out  1  one-cycle pulse, load_data valid.
REQ-018 stall  out  1  holds fetch/execute stages, combinational.
REQ-019 misalign  out  1  misaligned-access pulse (see Configuration).

Function
REQ-020 Memory op = ex_valid and opcode 0000011 (load) or 0100011 (store); all other opcodes ignored.
REQ-021 FSM states IDLE, REQ, WAIT, DONE.
REQ-022 IDLE: memory op present -> latch opcode, funct3, addr, wdata; go REQ; stall=1 that cycle.
REQ-023 REQ: dbus_req=1; dbus_we/addr/be/wdata stable until dbus_gnt; gnt with store -> DONE; gnt with load -> WAIT; stall=1.
REQ-024 WAIT: dbus_req=0; dbus_rvalid -> register extended data into load_data, go DONE; stall=1.
REQ-025 DONE: stall=0, load_valid=1 for loads only, next state IDLE; memory op presented in DONE is the completing instruction and is not re-issued.
REQ-026 dbus_rvalid outside WAIT ignored; dbus_gnt outside REQ ignored.
REQ-027 Latency: store = 3 cycles minimum (IDLE, REQ, DONE); load = 4 cycles minimum; each bus wait cycle adds one.
REQ-028 Store lanes: SB be=0001<<addr[1:0], byte replicated x4; SH be=0011<<(2*addr[1]), halfword replicated x2; SW be=1111.
REQ-029 Load extract: byte at addr[1:0], halfword at addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-030 Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
REQ-031 Unlisted funct3 values are treated as word access.

Reset
REQ-032 rst: state=IDLE, dbus_req=0, dbus_we=0, dbus_addr=0, dbus_be=0, dbus_wdata=0, load_data=0, load_valid=0, misalign=0; stall=0 unless a memory op is present.
REQ-033 rst mid-transaction abandons it; a later dbus_rvalid is ignored per REQ-026.

Configuration
REQ-034 Macro LSU_MISALIGN_TRAP_EN defined: misaligned op in IDLE issues no bus request, pulses misalign one cycle, stall=0, state stays IDLE.
REQ-035 LSU_MISALIGN_TRAP_EN undefined: misalign tied 0; misaligned ops issued with offending low address bits forced to 0.

Structure
REQ-036 Package lsu_pkg holds state enum, LOAD/STORE opcode constants, funct3 constants.
REQ-037 Combinational sub-module lsu_fmt performs store lane alignment and load extraction/extension.

Verification
REQ-038 SW addr=0x100, wdata=0xDEADBEEF, gnt on first REQ cycle -> dbus_addr=0x100, be=1111, stall high 2 cycles, DONE in cycle 3.
REQ-039 LB addr=0x203, rdata=0x80xxxxxx, rvalid 2 cycles after gnt -> load_data=0xFFFFFF80, load_valid one pulse, stall high 5 cycles.
REQ-040 SH addr=0x302, wdata=0x0000ABCD, gnt delayed 3 cycles -> be=1100, wdata=0xABCDABCD held constant all REQ cycles.
REQ-041 LW addr=0x401: with macro -> misalign pulse, dbus_req never asserted; without -> dbus_addr=0x400, be=1111.
REQ-042 rst asserted in WAIT, rvalid next cycle -> state IDLE, load_valid stays 0, stall low.
REQ-043 Back-to-back LW then SW -> second op accepted in IDLE cycle following DONE, first not re-issued.
